// File: rtl/div_iter.sv
// div_iter: iterative 32-bit radix-2 restoring divider for the HI/LO path.
// DIV (signed) and DIVU (unsigned). result = {HI = remainder, LO = quotient}.
// A nonzero-divisor operation runs 32 ON cycles and then one END cycle,
// where ready pulses. A zero divisor goes through DIVZERO and then END,
// and produces result 0. annul aborts any operation in flight.
// Optional feature: define DIV_EARLY_OUT_EN to finish in a single ON cycle
// when |dividend| < |divisor|.
module div_iter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  input  logic        annul,
  output logic        busy,
  output logic        ready,
  output logic [63:0] result
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIVZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  // Partial remainder: [63:32] = remainder, [31:0] = dividend/quotient.
  // The 65th bit only exists transiently in w_shift. The remainder is always
  // smaller than the divisor, so the top bit is 0 after every step.
  logic [63:0] r_prem;
  logic [31:0] r_divisor;   // |divisor|
  logic [4:0]  r_cnt;
  logic        r_neg_q;     // operand signs differ (signed mode)
  logic        r_neg_r;     // dividend negative (signed mode)
  logic [63:0] r_result;

  logic        w_accept;
  logic        w_zero;
  logic [31:0] w_abs1;
  logic [31:0] w_abs2;
  logic [64:0] w_shift;
  logic [32:0] w_diff;
  logic [63:0] w_step;
  logic [31:0] w_q_raw;
  logic [31:0] w_r_raw;
  logic [63:0] w_final;

`ifdef DIV_EARLY_OUT_EN
  logic        r_early;
  logic        w_early;
`endif

  assign w_accept = (r_state == S_IDLE) && start && !annul;
  assign w_zero   = (opdata2 == 32'h0);

  // The magnitude of 0x80000000 is 0x80000000, which is correct as an unsigned value.
  assign w_abs1 = (signed_div && opdata1[31]) ? (~opdata1 + 32'd1) : opdata1;
  assign w_abs2 = (signed_div && opdata2[31]) ? (~opdata2 + 32'd1) : opdata2;

  // One restoring step: shift, trial-subtract from the upper 33 bits, and keep the difference if it is non-negative.
  assign w_shift = {r_prem, 1'b0};
  assign w_diff  = w_shift[64:32] - {1'b0, r_divisor};

`ifdef DIV_EARLY_OUT_EN
  assign w_early = !w_zero && (w_abs1 < w_abs2);
  // Bypass step: the dividend becomes the remainder and the quotient is forced to zero.
  assign w_step  = r_early ? {r_prem[31:0], 32'h0}
                 : (w_diff[32] ? w_shift[63:0] : {w_diff[31:0], w_shift[31:1], 1'b1});
`else
  assign w_step  = w_diff[32] ? w_shift[63:0] : {w_diff[31:0], w_shift[31:1], 1'b1};
`endif

  // Signed fixup: the quotient is negated on a sign mismatch, and the remainder takes the sign of the dividend.
  assign w_q_raw = r_prem[31:0];
  assign w_r_raw = r_prem[63:32];
  assign w_final = {(r_neg_r ? (~w_r_raw + 32'd1) : w_r_raw),
                    (r_neg_q ? (~w_q_raw + 32'd1) : w_q_raw)};

  // State register.
  // NOTE: all clocked state uses non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next state and outputs. ready and result are gated by annul, so a
  // flushed END cycle neither pulses ready nor exposes a new result.
  // NOTE: every output gets a default first, so no path infers a latch.
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    ready  = 1'b0;
    result = r_result;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = w_zero ? S_DIVZERO : S_ON;
      end
      S_DIVZERO: begin
        busy   = 1'b1;
        w_next = annul ? S_IDLE : S_END;
      end
      S_ON: begin
        busy = 1'b1;
        if (annul)                w_next = S_IDLE;
        else if (r_cnt == 5'd31)  w_next = S_END;
      end
      S_END: begin
        w_next = S_IDLE;
        if (!annul) begin
          ready  = 1'b1;
          result = w_final;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, flush, and holding the result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_prem    <= 64'h0;
      r_divisor <= 32'h0;
      r_cnt     <= 5'd0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_result  <= 64'h0;
`ifdef DIV_EARLY_OUT_EN
      r_early   <= 1'b0;
`endif
    end else if (annul && (r_state != S_IDLE)) begin
      r_prem    <= 64'h0;
      r_cnt     <= 5'd0;
`ifdef DIV_EARLY_OUT_EN
      r_early   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_prem    <= {32'h0, w_abs1};
            r_divisor <= w_abs2;
            r_neg_q   <= signed_div && (opdata1[31] ^ opdata2[31]);
            r_neg_r   <= signed_div && opdata1[31];
`ifdef DIV_EARLY_OUT_EN
            r_early   <= w_early;
            r_cnt     <= w_early ? 5'd31 : 5'd0;
`else
            r_cnt     <= 5'd0;
`endif
          end
        end
        S_DIVZERO: begin
          // A zero partial remainder makes the END fixup produce result 0.
          r_prem <= 64'h0;
          r_neg_q <= 1'b0;
          r_neg_r <= 1'b0;
        end
        S_ON: begin
          r_prem <= w_step;
          r_cnt  <= r_cnt + 5'd1;
        end
        S_END: begin
          r_result <= w_final;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: a directed vector table, hand-written
// annul/reset/ignored-start sequences, and random operations checked against
// an arithmetic reference model.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic        busy;
  logic        ready;
  logic [63:0] result;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] last_exp = 64'h0;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[11];

  div_iter dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .annul      (annul),
    .busy       (busy),
    .ready      (ready),
    .result     (result)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer division. The remainder takes the sign of the dividend, and a zero divisor gives 0.
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint la, lb, q, r;
    if (b == 32'h0) return 64'h0;
    if (s) begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
    end else begin
      la = {32'h0, a};
      lb = {32'h0, b};
    end
    q = la / lb;
    r = la % lb;
    return {r[31:0], q[31:0]};
  endfunction

  // Expected cycle of the ready pulse, counted from the accepting edge.
  function automatic int exp_lat(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    ma = (s && a[31]) ? -a : a;
    mb = (s && b[31]) ? -b : b;
    if (b == 32'h0) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) return 2;
`else
    if (ma == mb + 32'd1) return 33;  // keep ma/mb referenced in both builds
`endif
    return 33;
  endfunction

  // Issue a start; returns at the negedge of cycle N+1.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; signed_div = s; opdata1 = a; opdata2 = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] res, output int lat, output int bcnt);
    res = 64'h0; lat = -1; bcnt = 0;
    issue(s, a, b);
    for (int k = 1; k <= 100; k++) begin
      if (k > 1) @(negedge clk);
      if (ready) begin
        lat = k;
        res = result;
        break;
      end
      if (busy) bcnt++;
    end
  endtask

  task automatic do_check(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
    logic [63:0] res;
    int lat, bcnt, el;
    el = exp_lat(s, a, b);
    run_op(s, a, b, res, lat, bcnt);
    check($sformatf("%s result", tag), res, exp);
    check($sformatf("%s ready_cycle", tag), lat, el);
    check($sformatf("%s busy_cycles", tag), bcnt, el - 1);
    @(negedge clk);
    check($sformatf("%s ready_width", tag), ready, 1'b0);
    check($sformatf("%s result_held", tag), result, exp);
    last_exp = exp;
  endtask

  initial begin
    int seen;
    logic [63:0] res;
    int lat, bcnt;

    vecs[0]  = '{1'b0, 32'd100,       32'd7,        {32'd2, 32'd14}};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,  32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}};
    vecs[2]  = '{1'b1, 32'd7,         32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}};
    vecs[3]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF, {32'd0, 32'h80000000}};
    vecs[4]  = '{1'b0, 32'hFFFFFFFF,  32'd1,        {32'd0, 32'hFFFFFFFF}};
    vecs[5]  = '{1'b0, 32'd5,         32'd0,        64'h0};
    vecs[6]  = '{1'b0, 32'd9,         32'd3,        {32'd0, 32'd3}};
    vecs[7]  = '{1'b0, 32'd3,         32'd10,       {32'd3, 32'd0}};
    vecs[8]  = '{1'b1, 32'hFFFFFFF8,  32'hFFFFFFFD, {32'hFFFFFFFE, 32'd2}};
    vecs[9]  = '{1'b0, 32'h80000000,  32'hFFFFFFFF, {32'h80000000, 32'd0}};
    vecs[10] = '{1'b1, 32'h80000000,  32'd0,        64'h0};

    resetn = 1'b0; start = 1'b0; signed_div = 1'b0; opdata1 = '0; opdata2 = '0; annul = 1'b0;
    #12;
    check("reset busy", busy, 1'b0);
    check("reset ready", ready, 1'b0);
    check("reset result", result, 64'h0);
    @(negedge clk);
    resetn = 1'b1;

    // Directed vectors
    for (int i = 0; i < 11; i++)
      do_check($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp);

    // start and annul in the same IDLE cycle: annul wins
    @(negedge clk);
    start = 1'b1; annul = 1'b1; signed_div = 1'b0; opdata1 = 32'd50; opdata2 = 32'd5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    check("start_annul busy", busy, 1'b0);
    check("start_annul result", result, last_exp);

    // annul in cycle N+10: no ready, result unchanged, IDLE at N+11
    issue(1'b0, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    annul = 1'b1;
    #1;
    check("annul_on busy_before", busy, 1'b1);
    @(negedge clk);
    annul = 1'b0;
    check("annul_on busy_after", busy, 1'b0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready) seen++;
    end
    check("annul_on no_ready", seen, 0);
    check("annul_on result", result, last_exp);

    // annul in the END cycle suppresses the pulse and the update
    issue(1'b0, 32'd50, 32'd5);
    repeat (32) @(negedge clk);
    annul = 1'b1;
    #1;
    check("annul_end ready", ready, 1'b0);
    check("annul_end result", result, last_exp);
    @(negedge clk);
    annul = 1'b0;
    check("annul_end busy", busy, 1'b0);
    check("annul_end result_after", result, last_exp);

    // start while busy is ignored
    issue(1'b0, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    start = 1'b1; opdata1 = 32'd1; opdata2 = 32'd1;
    @(negedge clk);
    start = 1'b0;
    lat = -1; res = 64'h0;
    for (int k = 6; k <= 100; k++) begin
      if (k > 6) @(negedge clk);
      if (ready) begin
        lat = k;
        res = result;
        break;
      end
    end
    check("busy_start ready_cycle", lat, 33);
    check("busy_start result", res, {32'd2, 32'd14});
    @(negedge clk);
    check("busy_start idle", busy, 1'b0);
    last_exp = {32'd2, 32'd14};

    // asynchronous reset in the middle of ON
    issue(1'b1, 32'hFFFFF000, 32'd17);
    repeat (4) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("midreset busy", busy, 1'b0);
    check("midreset ready", ready, 1'b0);
    check("midreset result", result, 64'h0);
    @(negedge clk);
    resetn = 1'b1;
    do_check("post_reset", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3});

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      logic s;
      logic [31:0] a, b;
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = $urandom;
        1: b = $urandom_range(0, 15);
        2: b = 32'hFFFFFFFF - $urandom_range(0, 7);
        3: b = $urandom_range(1, 100000);
        default: begin a = 32'h80000000; b = $urandom_range(0, 3) == 0 ? 32'hFFFFFFFF : $urandom; end
      endcase
      if ($urandom_range(0, 5) == 0) a = $urandom_range(0, 20);
      do_check($sformatf("rand%0d", i), s, a, b, model(s, a, b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
